uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_PER_BIT, default 868: clock cycles per bit (100 MHz / 115200 baud); SHALL be >= 3.
REQ-002 Parameter PACK_SIZE, default 8: data bits per frame.
REQ-003 Parameter PARITY_EN, default 0: 1 means a parity bit follows the data bits.
REQ-004 Parameter EVEN_PAR, default 0: 1 means even parity, 0 means odd parity.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port rx_bit, input, 1 bit: serial line; asynchronous to clk; idles high.
REQ-008 Port rx_byte_data, output, PACK_SIZE bits: last received data word.
REQ-009 Port rx_byte_valid, output, 1 bit: one-cycle pulse; rx_byte_data is valid in that cycle.
REQ-010 Port rx_parity_err, output, 1 bit: one-cycle pulse, coincident with rx_byte_valid, when the parity check fails.
REQ-011 Port rx_frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-012 Port rx_active, output, 1 bit: high from start-bit validation until the frame ends.

Function
REQ-013 rx_bit SHALL pass through a two-flop synchronizer, reset to 1; all decisions SHALL use the synchronized value (rx_s).
REQ-014 States: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE: clear the counter and bit index; on rx_s==0, go to START.
REQ-016 START: count to (CLK_PER_BIT-1)/2 (integer division).
- If rx_s==0 there: clear the counter, set rx_active, go to DATA.
- Otherwise (glitch): go to IDLE; no output pulse.
REQ-017 DATA: count to CLK_PER_BIT-1, then sample rx_s into data bit [index], LSB first, and clear the counter.
- After bit PACK_SIZE-1: go to PARITY if PARITY_EN, else to STOP.
REQ-018 PARITY: count to CLK_PER_BIT-1, then sample the parity bit and go to STOP.
- Expected parity bit: XOR of the data bits when EVEN_PAR=1; XNOR of the data bits when EVEN_PAR=0.
REQ-019 STOP: count to CLK_PER_BIT-1, then sample rx_s.
- If 1: in the next cycle, pulse rx_byte_valid and update rx_byte_data; pulse rx_parity_err if PARITY_EN and the parity mismatched; clear rx_active; go to IDLE.
- If 0: pulse rx_frame_err only (no valid, rx_byte_data unchanged); clear rx_active; go to BREAK.
REQ-020 BREAK: wait for rx_s==1, then go to IDLE, so that a held-low line does not retrigger reception.
REQ-021 Sampling SHALL occur at mid-bit. The valid pulse therefore occurs about half a bit before the stop-bit end, and back-to-back frames (next start bit immediately after the stop bit) SHALL be received with no loss.
REQ-022 Counter width SHALL be $clog2(CLK_PER_BIT). Index width SHALL be max(1, $clog2(PACK_SIZE)). Comparisons SHALL use >= so that no value wraps.
REQ-023 Total latency, from the line falling edge of the start bit to rx_byte_valid, SHALL be 2 + (CLK_PER_BIT-1)/2 + 1 + (PACK_SIZE + PARITY_EN + 1) x CLK_PER_BIT + 1 cycles, within ±1 cycle.
REQ-024 An illegal state encoding SHALL return to IDLE in the next cycle.

Reset
REQ-025 While rst is high:
- State is IDLE.
- Synchronizer flops are 1.
- Counter and index are 0.
- rx_byte_data is 0.
- rx_byte_valid, rx_parity_err, rx_frame_err and rx_active are 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulses. After release, reception SHALL resume from IDLE on the next falling edge.

Structure
REQ-027 The rx state enum and a parity-function helper SHALL live in a shared package uart_pkg, used by both uart_rx and the existing transmitter.
REQ-028 The synchronizer SHALL be a separate sub-module, sync_2ff (parameter RST_VAL).

Verification
REQ-029 The bench SHALL use CLK_PER_BIT=5, PACK_SIZE=8, PARITY_EN=1 and EVEN_PAR=1, and drive ideal frames.
REQ-030 Frame 0xAA with parity 0 and stop 1 -> exactly one rx_byte_valid pulse with rx_byte_data=0xAA; rx_parity_err=0; rx_frame_err=0.
REQ-031 Frame 0xAA with parity bit 1 -> rx_byte_valid and rx_parity_err pulse in the same cycle; rx_byte_data=0xAA.
REQ-032 Frame 0x3C with stop bit 0, line held low 20 cycles, then high -> one rx_frame_err pulse, no rx_byte_valid, no retrigger; a following 0x81 frame is received correctly.
REQ-033 A 1-cycle low glitch on rx_bit -> rx_active never rises; no pulses.
REQ-034 Frames 0x55 and 0x0F back-to-back with no idle gap -> two valid pulses, in order, with the correct data.
REQ-035 rst asserted during data bit 4 of a frame -> all outputs are 0 immediately; the next frame, 0xC3, is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding and parity helper,
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  // Parity bit for a data word (zero-extended to 32 bits).
  // even=1: XOR of the bits; even=0: XNOR of the bits.
  function automatic logic par_calc(
    input logic [31:0] d,
    input logic        even
  );
    return even ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, rst (async, active-high), d (async in), q (synced out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, optional parity, framing/break handling.
// Ports: clk, rst (async high), rx_bit (serial in); outputs rx_byte_data,
// rx_byte_valid / rx_parity_err / rx_frame_err pulses, rx_active.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int PACK_SIZE   = 8,
  parameter int PARITY_EN   = 0,
  parameter int EVEN_PAR    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bit,
  output logic [PACK_SIZE-1:0] rx_byte_data,
  output logic                 rx_byte_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_active
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = (PACK_SIZE > 1) ? $clog2(PACK_SIZE) : 1;

  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLK_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(PACK_SIZE - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_bit),
    .q   (rx_s)
  );

  rx_state_t            st, st_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [PACK_SIZE-1:0] sh, sh_d;
  logic                 pbit, pbit_d;
  logic [PACK_SIZE-1:0] data_d;
  logic                 valid_d, perr_d, ferr_d, act_d;
  logic                 half_done, bit_done;

  assign half_done = (cnt >= HALF);
  assign bit_done  = (cnt >= FULL);

  always_comb begin
    st_d    = st;
    cnt_d   = cnt;
    idx_d   = idx;
    sh_d    = sh;
    pbit_d  = pbit;
    data_d  = rx_byte_data;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    act_d   = rx_active;
    case (st)
      RX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) st_d = RX_START;
      end
      RX_START: begin
        if (half_done) begin
          cnt_d = '0;
          if (!rx_s) begin
            act_d = 1'b1;
            st_d  = RX_DATA;
          end else begin
            st_d  = RX_IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_done) begin
          cnt_d     = '0;
          sh_d[idx] = rx_s;
          if (idx >= LAST) begin
            idx_d = '0;
            st_d  = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          end else begin
            idx_d = idx + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_PARITY: begin
        if (bit_done) begin
          cnt_d  = '0;
          pbit_d = rx_s;
          st_d   = RX_STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          act_d = 1'b0;
          if (rx_s) begin
            valid_d = 1'b1;
            data_d  = sh;
            perr_d  = (PARITY_EN != 0) &&
                      (pbit != par_calc(32'(sh), EVEN_PAR != 0));
            st_d    = RX_IDLE;
          end else begin
            ferr_d = 1'b1;
            st_d   = RX_BREAK;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      // Hold off until the line returns high so a break is one event.
      RX_BREAK: begin
        if (rx_s) st_d = RX_IDLE;
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= RX_IDLE;
      cnt           <= '0;
      idx           <= '0;
      sh            <= '0;
      pbit          <= 1'b0;
      rx_byte_data  <= '0;
      rx_byte_valid <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_active     <= 1'b0;
    end else begin
      st            <= st_d;
      cnt           <= cnt_d;
      idx           <= idx_d;
      sh            <= sh_d;
      pbit          <= pbit_d;
      rx_byte_data  <= data_d;
      rx_byte_valid <= valid_d;
      rx_parity_err <= perr_d;
      rx_frame_err  <= ferr_d;
      rx_active     <= act_d;
    end
  end

endmodule
